imem_loader: RTL and testbench

- Boot-time program loader and controller for the single-port instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit little-endian words.
- Writes each word to sequential instruction-memory addresses starting at 0.
- Holds the CPU (PC frozen) until the requested word count is loaded, then releases it and reports completion.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 102 ++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus between the boot source and the loader.
// master = stream source / memory side, slave = imem_loader.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them to
// consecutive imem addresses from 0 and holds the CPU until the requested count is in.
//
// state | meaning
// IDLE  | no load in progress, CPU held, waiting for a legal start
// RECV  | collecting the four bytes of the current word
// WRITE | one-cycle imem write of the assembled word
// DONE  | all words written, CPU released
module imem_loader #(
  parameter int DEPTH  = 18,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [ADDR_W:0] word_count,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            error
);

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t          state;
  logic [1:0]      byte_idx;
  logic [ADDR_W:0] count;
  logic            start_ok;
  logic            last_word;

  assign start_ok  = (word_count != '0) && (word_count <= MAX_COUNT);
  assign last_word = ({1'b0, bus.mem_addr} == (count - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cpu_hold       <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      byte_idx       <= '0;
      count          <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      // A start is honoured only between loads; mid-load starts fall through to the case.
      if (start && (state == IDLE || state == DONE)) begin
        done     <= 1'b0;
        cpu_hold <= 1'b1;
        if (start_ok) begin
          count          <= word_count;
          bus.mem_addr   <= '0;
          byte_idx       <= '0;
          error          <= 1'b0;
          bus.byte_ready <= 1'b1;
          state          <= RECV;
        end else begin
          error <= 1'b1;
          state <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            bus.byte_ready <= 1'b0;
            cpu_hold       <= 1'b1;
          end
          RECV: begin
            if (bus.byte_valid && bus.byte_ready) begin
              bus.mem_wdata[{byte_idx, 3'b000} +: 8] <= bus.byte_data;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                bus.byte_ready <= 1'b0;
                bus.mem_we     <= 1'b1;
                state          <= WRITE;
              end
            end
          end
          WRITE: begin
            if (last_word) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= DONE;
            end else begin
              bus.mem_addr   <= bus.mem_addr + 1'b1;
              bus.byte_ready <= 1'b1;
              state          <= RECV;
            end
          end
          DONE: begin
            bus.byte_ready <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a byte-stream source, a memory image of the writes,
// and a word-level model (bytes -> little-endian words at addresses 0..n-1).
module tb_imem_loader;
  localparam int DEPTH  = 18;
  localparam int ADDR_W = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [ADDR_W:0] word_count;
  logic            cpu_hold;
  logic            done;
  logic            error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          ncyc      = 0;
  int          total_wr  = 0;
  int          oob_cnt   = 0;
  int          done_rise = -1;
  logic        done_q    = 1'b0;
  logic [7:0]  stream[$];
  int          wr_cyc[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          hs4[$];
  logic [31:0] mem_img [DEPTH];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to the next falling edge and record any memory write seen there.
  task automatic tick();
    int a;
    @(negedge clk);
    ncyc++;
    if (bus.mem_we === 1'b1) begin
      a = int'(bus.mem_addr);
      total_wr++;
      wr_cyc.push_back(ncyc);
      wr_addr.push_back(a);
      wr_data.push_back(bus.mem_wdata);
      if (a < DEPTH) mem_img[a] = bus.mem_wdata;
      else oob_cnt++;
    end
    if (done === 1'b1 && done_q !== 1'b1) done_rise = ncyc;
    done_q = done;
  endtask

  function automatic logic [31:0] word_of(input int k);
    return 32'(stream[4*k]) + (32'(stream[4*k+1]) << 8)
         + (32'(stream[4*k+2]) << 16) + (32'(stream[4*k+3]) << 24);
  endfunction

  task automatic fill_stream(input int n);
    stream.delete();
    for (int i = 0; i < 4*n; i++) stream.push_back(8'($urandom));
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    hs4.delete();
    done_rise = -1;
  endtask

  // Drive the stream; a byte counts as taken when valid is driven while ready is seen high.
  task automatic feed(input int nbytes, input int pct, input int mid_start);
    int   i;
    int   budget;
    bit   fired;
    logic v;
    i = 0;
    budget = nbytes * 30 + 40;
    fired = 1'b0;
    while (i < nbytes && budget > 0) begin
      v = ($urandom_range(99) < pct);
      if (!fired && i == mid_start) begin
        start = 1'b1;
        word_count = (ADDR_W+1)'(1);
        fired = 1'b1;
      end else begin
        start = 1'b0;
      end
      bus.byte_valid = v;
      bus.byte_data  = v ? stream[i] : 8'($urandom);
      if (v && bus.byte_ready === 1'b1) begin
        if (i % 4 == 3) hs4.push_back(ncyc + 1);
        i++;
      end
      tick();
      budget--;
    end
    start = 1'b0;
    bus.byte_valid = 1'b0;
    check_val("feed_bytes", i, nbytes);
  endtask

  task automatic run_load(input int n, input int pct, input int mid_start);
    clear_log();
    start = 1'b1;
    word_count = (ADDR_W+1)'(n);
    tick();
    start = 1'b0;
    check_val("start_state", {cpu_hold, done, bus.byte_ready, error}, 4'b1010);
    feed(4*n, pct, mid_start);
    for (int w = 0; w < 10 && done !== 1'b1; w++) tick();
    check_val("wr_count", wr_cyc.size(), n);
    for (int k = 0; k < n && k < wr_cyc.size(); k++) begin
      check_val("wr_addr", wr_addr[k], k);
      check_val("wr_data", wr_data[k], word_of(k));
      if (k < hs4.size()) check_val("wr_latency", wr_cyc[k], hs4[k]);
    end
    if (wr_cyc.size() > 0) check_val("done_latency", done_rise, wr_cyc[wr_cyc.size()-1] + 1);
    check_val("final_state", {done, cpu_hold, bus.byte_ready, bus.mem_we, error}, 5'b10000);
    check_val("addr_hold", bus.mem_addr, n - 1);
  endtask

  task automatic illegal_start(input int wc);
    int w0;
    w0 = total_wr;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    start = 1'b1;
    word_count = (ADDR_W+1)'(wc);
    tick();
    start = 1'b0;
    repeat (4) tick();
    bus.byte_valid = 1'b0;
    check_val("err_state", {error, done, cpu_hold, bus.byte_ready}, 4'b1010);
    check_val("err_no_write", total_wr - w0, 0);
  endtask

  initial begin
    logic [31:0] saved_w0;
    int          n;
    int          pct;

    rst_n = 1'b0;
    start = 1'b0;
    word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    for (int i = 0; i < DEPTH; i++) mem_img[i] = '0;

    repeat (3) tick();
    check_val("rst_values", {error, bus.mem_addr, bus.mem_wdata}, '0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val("rst_idle", {cpu_hold, done, bus.byte_ready, bus.mem_we}, 4'b1000);
    end

    illegal_start(0);
    illegal_start(19);
    fill_stream(1);
    run_load(1, 100, -1);

    stream = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 100, -1);
    run_load(2, 50, -1);

    illegal_start(63);
    fill_stream(2);
    run_load(2, 75, -1);

    for (int r = 0; r < 3; r++) begin
      n   = $urandom_range(DEPTH, 1);
      pct = $urandom_range(100, 30);
      fill_stream(n);
      run_load(n, pct, -1);
    end

    fill_stream(3);
    run_load(3, 70, 5);
    fill_stream(DEPTH);
    run_load(DEPTH, 80, -1);

    // Abort a two-word load after six bytes: word 0 is already in memory.
    fill_stream(2);
    clear_log();
    start = 1'b1;
    word_count = (ADDR_W+1)'(2);
    tick();
    start = 1'b0;
    feed(6, 100, -1);
    check_val("abort_word0", mem_img[0], word_of(0));
    saved_w0 = word_of(0);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_ctl", {cpu_hold, done, error, bus.byte_ready, bus.mem_we}, 5'b10000);
    check_val("abort_addr", bus.mem_addr, 0);
    check_val("abort_wdata", bus.mem_wdata, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("abort_keep0", mem_img[0], saved_w0);
    fill_stream(1);
    run_load(1, 60, -1);

    check_val("addr_range", oob_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
